// File: rtl/mux16_arb_pkg.sv
// Shared constants, state encoding and helpers for the 16-way round-robin
// mux arbiter.
package mux16_arb_pkg;

    localparam int NREQ = 16;
    localparam int SELW = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Index to one-hot grant vector.
    function automatic logic [NREQ-1:0] onehot(input logic [SELW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux16_rr_arbiter_rr_pick16.sv
// Round-robin winner search: the first set request bit found searching
// upward from last_owner+1, wrapping from 15 to 0. last_owner itself is
// checked last, so a lone requester still wins.
module rr_pick16
    import mux16_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [SELW-1:0] last_owner,
    output logic            any,
    output logic [SELW-1:0] winner
);

    // Scan offsets 1..16; the 4-bit add supplies the wrap-around.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!any && req[last_owner + SELW'(i)]) begin
                any    = 1'b1;
                winner = last_owner + SELW'(i);
            end
        end
    end

endmodule

// File: rtl/mux16to1.sv
// 16-to-1 single-bit multiplexer shared by all requesters.
module mux16to1
    import mux16_arb_pkg::*;
(
    input  logic [NREQ-1:0] in,
    input  logic [SELW-1:0] sel,
    output logic            out
);

    // Pure combinational bit select.
    always_comb begin
        out = in[sel];
    end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter and sequencer sharing one 16-to-1 bit mux among
// 16 requesters, with a valid/ready output and a per-tenure burst limit.
// Optional feature macro: MUX16_ARB_LOCK_EN (lock input extends a tenure
// past MAX_BURST). With the macro undefined, the lock port is ignored.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | arbitration cycle; no grant; a winner is latched if req != 0
//  GRANT | owner drives the mux; each valid&&ready cycle is one beat
module mux16_rr_arbiter
    import mux16_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] data_in,
    input  logic            lock,
    output logic [NREQ-1:0] gnt,
    output logic [SELW-1:0] sel,
    output logic            out_valid,
    output logic            out_data,
    input  logic            out_ready
);

    localparam logic [SELW-1:0] C_CNT_LAST = SELW'(MAX_BURST - 1);

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic [SELW-1:0] r_owner;
    logic [SELW-1:0] w_owner_nxt;
    logic [SELW-1:0] r_last;
    logic [SELW-1:0] w_last_nxt;
    logic [SELW-1:0] r_cnt;
    logic [SELW-1:0] w_cnt_nxt;
    logic [SELW-1:0] w_cnt_inc;

    logic            w_any;
    logic [SELW-1:0] w_winner;
    logic            w_beat;
    logic            w_req_own;
    logic            w_limit_hit;

    rr_pick16 u_pick (
        .req        (req),
        .last_owner (r_last),
        .any        (w_any),
        .winner     (w_winner)
    );

    assign w_req_own = req[r_owner];
    assign w_beat    = (r_state == GRANT) && out_ready;

`ifdef MUX16_ARB_LOCK_EN
    // While locked the limit is suppressed and cnt saturates; once lock
    // falls, any beat at or beyond the limit closes the tenure.
    assign w_limit_hit = w_beat && !lock && (r_cnt >= C_CNT_LAST);
    assign w_cnt_inc   = (r_cnt == {SELW{1'b1}}) ? r_cnt : r_cnt + SELW'(1);
`else
    logic w_lock_unused;

    // cnt never passes the limit here, so an equality compare suffices.
    assign w_limit_hit   = w_beat && (r_cnt == C_CNT_LAST);
    assign w_cnt_inc     = r_cnt + SELW'(1);
    assign w_lock_unused = lock;
`endif

    // State, owner, last-owner and burst-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_last  <= {SELW{1'b1}};
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: arbitrate in IDLE, count beats and detect the
    // end of tenure in GRANT. A beat in the cycle req[owner] drops still
    // counts as transferred; the tenure ends either way.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = GRANT;
                    w_owner_nxt = w_winner;
                    w_last_nxt  = w_winner;
                    w_cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (w_beat) begin
                    w_cnt_nxt = w_cnt_inc;
                end
                if (!w_req_own || w_limit_hit) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only; req never reaches them
    // combinationally.
    always_comb begin
        gnt       = (r_state == GRANT) ? onehot(r_owner) : '0;
        sel       = r_owner;
        out_valid = (r_state == GRANT);
    end

    mux16to1 u_mux (
        .in  (data_in),
        .sel (sel),
        .out (out_data)
    );

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed bench for mux16_rr_arbiter with MAX_BURST=4.
module tb_mux16_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic [15:0] data_in;
    logic        lock;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        out_valid;
    logic        out_data;
    logic        out_ready;

    int n_cmp;
    int n_err;

    mux16_rr_arbiter #(.MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data_in),
        .lock      (lock),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        lock = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        req       = '0;
        lock      = 1'b0;
        out_ready = 1'b0;
        data_in   = 16'hA5A5;
        step();
        step();

        // Reset values
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data1", 32'(out_data), 32'h1);
        data_in = 16'hA5A4;
        #1;
        chk("rst_data0", 32'(out_data), 32'h0);

        // Single requester 0: 4 beats, one IDLE bubble, re-grant
        rst = 1'b0;
        req = 16'h0001;
        out_ready = 1'b1;
        chk("t1_idle0", 32'(gnt), 32'h0);
        step();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t1_gnt%0d", k), 32'(gnt), 32'h0001);
            chk($sformatf("t1_valid%0d", k), 32'(out_valid), 32'h1);
            step();
        end
        chk("t1_bubble_gnt", 32'(gnt), 32'h0);
        chk("t1_bubble_valid", 32'(out_valid), 32'h0);
        step();
        chk("t1_regrant", 32'(gnt), 32'h0001);

        // Requesters 0 and 15 alternate
        do_reset();
        req = 16'h8001;
        step();
        for (int t = 0; t < 3; t++) begin
            chk($sformatf("t2_sel_t%0d", t), 32'(sel), (t % 2 == 0) ? 32'd0 : 32'd15);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("t2_gnt_t%0d_b%0d", t, k), 32'(gnt),
                    (t % 2 == 0) ? 32'h0001 : 32'h8000);
                step();
            end
            chk($sformatf("t2_gap_t%0d", t), 32'(gnt), 32'h0);
            step();
        end

        // Owner 5 with back-pressure
        do_reset();
        req = 16'h0020;
        data_in = 16'h0020;
        step();
        chk("t3_gnt", 32'(gnt), 32'h0020);
        chk("t3_sel", 32'(sel), 32'd5);
        chk("t3_data_b0", 32'(out_data), 32'h1);
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            data_in = (k % 2 == 0) ? 16'h0000 : 16'h0020;
            #1;
            chk($sformatf("t3_hold_valid%0d", k), 32'(out_valid), 32'h1);
            chk($sformatf("t3_hold_gnt%0d", k), 32'(gnt), 32'h0020);
            chk($sformatf("t3_hold_data%0d", k), 32'(out_data), (k % 2 == 0) ? 32'h0 : 32'h1);
            step();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data_in = (k % 2 == 0) ? 16'h0020 : 16'hFFDF;
            #1;
            chk($sformatf("t3_resume_gnt%0d", k), 32'(gnt), 32'h0020);
            chk($sformatf("t3_resume_data%0d", k), 32'(out_data), (k % 2 == 0) ? 32'h1 : 32'h0);
            step();
        end
        chk("t3_end", 32'(gnt), 32'h0);

        // Owner 3 drops after 2 beats; requester 9 follows
        do_reset();
        req = 16'h0208;
        step();
        chk("t4_gnt_b0", 32'(gnt), 32'h0008);
        step();
        chk("t4_gnt_b1", 32'(gnt), 32'h0008);
        req = 16'h0200;
        #1;
        chk("t4_gnt_drop", 32'(gnt), 32'h0008);
        step();
        chk("t4_idle", 32'(gnt), 32'h0);
        step();
        chk("t4_gnt9", 32'(gnt), 32'h0200);
        chk("t4_sel9", 32'(sel), 32'd9);

        // Reset mid-tenure of owner 7
        do_reset();
        req = 16'h0080;
        step();
        chk("t5_gnt7", 32'(gnt), 32'h0080);
        step();
        rst = 1'b1;
        step();
        chk("t5_rst_gnt", 32'(gnt), 32'h0);
        chk("t5_rst_valid", 32'(out_valid), 32'h0);
        chk("t5_rst_sel", 32'(sel), 32'h0);
        rst = 1'b0;
        req = 16'hFFFF;
        step();
        chk("t5_first_gnt", 32'(gnt), 32'h0001);

        // Lock on owner 2
        do_reset();
        req = 16'h0004;
        lock = 1'b1;
        step();
`ifdef MUX16_ARB_LOCK_EN
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("t6_lock_gnt%0d", k), 32'(gnt), 32'h0004);
            step();
        end
        lock = 1'b0;
        #1;
        chk("t6_unlock_beat", 32'(gnt), 32'h0004);
        step();
        chk("t6_end", 32'(gnt), 32'h0);
`else
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t6_nolock_gnt%0d", k), 32'(gnt), 32'h0004);
            step();
        end
        chk("t6_nolock_end", 32'(gnt), 32'h0);
`endif
        lock = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux16_rr_arbiter.md
# mux16_rr_arbiter

- Round-robin arbiter and sequencer that shares one 16-to-1 bit multiplexer among 16 requesters.
- Picks one requester, drives the 4-bit mux select, and presents the selected bit downstream under a valid/ready handshake.
- Bounds each tenure to a burst limit so no requester starves the others.
- Sits between the 16 producer lanes and any single-bit serial consumer; the mux datapath is instantiated inside.

## Interface
Parameters:
- MAX_BURST, 4: maximum beats per tenure; legal range 1..16.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- req  input  16  per-requester request; held by the requester for as long as it wants service.
- data_in  input  16  per-requester data bit; bit i belongs to requester i.
- lock  input  1  owner asks to extend its tenure past MAX_BURST; see Configuration.
- gnt  output  16  one-hot grant, all-zero when idle.
- sel  output  4  index of the current owner, drives the mux select.
- out_valid  output  1  downstream data valid.
- out_data  output  1  data_in[sel], taken through the mux.
- out_ready  input  1  downstream accepts the beat.

## Operation
- States: IDLE and GRANT.
- IDLE, arbitration:
  - If req is non-zero, the winner is the first set bit searching upward from (last_owner+1) mod 16, wrapping at 15 to 0.
  - Next cycle: state GRANT, owner=winner, last_owner=winner, burst count cnt=0.
  - If req is zero, stay in IDLE.
- GRANT:
  - gnt = one-hot(owner), sel = owner, out_valid = 1, out_data = data_in[owner].
  - A beat is a cycle with out_valid && out_ready; each beat increments cnt.
- Tenure ends, returning to IDLE next cycle, when either:
  - a beat occurs with cnt == MAX_BURST-1, or
  - req[owner] is 0 in any GRANT cycle.
- If req[owner] drops in the same cycle as a beat, the beat counts as transferred and the tenure ends.
- Requests from non-owners during GRANT are ignored until the next IDLE cycle.
- Widths: cnt is 4 bits (values 0..15); the comparison uses MAX_BURST-1; no other arithmetic.
- Only one requester requesting: it is re-granted after each one-cycle IDLE gap.

## Timing
- Reset values:
  - state IDLE, last_owner=15 (requester 0 wins first), cnt=0.
  - gnt=0, sel=0, out_valid=0.
  - out_data = data_in[0], since sel=0 and the mux is combinational.
- Arbitration latency: req seen in IDLE at cycle N gives gnt/out_valid asserted at cycle N+1.
- One mandatory IDLE bubble cycle between consecutive tenures.
- gnt, sel and out_valid are decoded from registered state and owner only, with no combinational path from req.
- out_data is combinational from data_in through the mux.
- out_ready has no effect in IDLE. In GRANT, out_ready low holds the beat, and out_valid stays high until the beat transfers or req[owner] drops.
- rst asserted mid-tenure: next cycle all reset values apply, the partial burst is discarded, and no beat is reported.

## Configuration
- Macro: MUX16_ARB_LOCK_EN.
- Defined: while lock=1 in GRANT, the burst-limit exit is suppressed. cnt saturates at 15, and the tenure ends only when req[owner] drops, or by the burst-limit rule on the first beat after lock falls once cnt ≥ MAX_BURST-1.
- Undefined: the lock port is present but ignored, and the burst limit always applies.

## Structure
- Package mux16_arb_pkg holds:
  - constants NREQ=16 and SELW=4;
  - the state enum {IDLE, GRANT};
  - a function one-hot(index).
- Sub-module rr_pick16: combinational, inputs req[15:0] and last_owner[3:0], outputs any and winner[3:0].
- The datapath instantiates the existing mux16to1 with in=data_in, sel=sel, out=out_data.

## Test plan
- Reset, then req=16'h0001, out_ready=1, MAX_BURST=4 → gnt=16'h0001 one cycle after req. Exactly 4 beats, then one IDLE cycle, then gnt=16'h0001 again.
- req=16'h8001 held, out_ready=1 → grant order 0,15,0,15… Each tenure is 4 beats with a one-cycle gap between tenures.
- Owner 5 (data_in[5] toggling), out_ready low for 3 cycles → out_valid held and cnt unchanged. Beats resume when out_ready rises, and out_data tracks data_in[5].
- Owner 3 drops req[3] after 2 beats while req[9]=1 → IDLE next cycle, then gnt=16'h0200, sel=9.
- rst pulsed mid-tenure of owner 7 → next cycle gnt=0 and out_valid=0. With req=16'hFFFF, the first grant afterwards is requester 0.
- MUX16_ARB_LOCK_EN defined, owner 2 with lock=1 for 10 beats → tenure continues past 4 beats. When lock falls, the tenure ends on the next beat.
